// File: rtl/mux_pkg.sv
// Shared types and constants for the registered three-way select mux.
package mux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        SEL_A       = 2'b00,
        SEL_B       = 2'b01,
        SEL_C       = 2'b10,
        SEL_ILLEGAL = 2'b11
    } sel_e;

    function automatic logic is_legal_sel(input logic [1:0] code);
        return (code == SEL_A) || (code == SEL_B) || (code == SEL_C);
    endfunction

endpackage

// File: rtl/mux_intf.sv
// Signal bundle used to hook the mux up to a bench or a neighbouring block.
interface MUX_intf #(
    parameter int unsigned WIDTH = mux_pkg::DEFAULT_WIDTH
);
    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [1:0]       cntl;
    logic [WIDTH-1:0] out;
    logic             sel_err;
endinterface

// File: rtl/mux_sel_comb.sv
// Combinational next-value selection: picks A/B/C, or holds and flags an illegal code.
module mux_sel_comb
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [1:0]       cntl,
    input  logic [WIDTH-1:0] hold_data,
    output logic [WIDTH-1:0] next_data,
    output logic             illegal
);

    always_comb begin
        next_data = hold_data;
        illegal   = 1'b1;
        // An unknown select code falls through to the default arm, so it holds too.
        case (cntl)
            SEL_A: begin
                next_data = A;
                illegal   = 1'b0;
            end
            SEL_B: begin
                next_data = B;
                illegal   = 1'b0;
            end
            SEL_C: begin
                next_data = C;
                illegal   = 1'b0;
            end
            default: begin
                next_data = hold_data;
                illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mux.sv
// Registered three-way mux with an illegal-select flag; one cycle of latency.
module mux
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [1:0]       cntl,
    output logic [WIDTH-1:0] MUXOut,
    output logic             sel_err
);

    logic [WIDTH-1:0] mux_out_q;
    logic [WIDTH-1:0] mux_out_d;
    logic             sel_err_q;
    logic             sel_err_d;

    mux_sel_comb #(
        .WIDTH(WIDTH)
    ) u_sel (
        .A        (A),
        .B        (B),
        .C        (C),
        .cntl     (cntl),
        .hold_data(mux_out_q),
        .next_data(mux_out_d),
        .illegal  (sel_err_d)
    );

    // Reset wins over any select code, including the illegal one.
    always_ff @(posedge clk) begin
        if (reset) begin
            mux_out_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            mux_out_q <= mux_out_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign MUXOut  = mux_out_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux.sv
// Self-checking bench for mux: directed vector table, corner sequences, random sweep.
module tb_mux;

    localparam int unsigned W = 32;

    MUX_intf #(.WIDTH(W)) intf ();

    mux #(
        .WIDTH(W)
    ) dut (
        .clk    (intf.clk),
        .reset  (intf.reset),
        .A      (intf.A),
        .B      (intf.B),
        .C      (intf.C),
        .cntl   (intf.cntl),
        .MUXOut (intf.out),
        .sel_err(intf.sel_err)
    );

    initial intf.clk = 1'b0;
    always #5 intf.clk = ~intf.clk;

    typedef struct {
        logic         rst;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [1:0]   sel;
        logic [W-1:0] exp_out;
        logic         exp_err;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [1:0] sel);
        intf.reset = rst;
        intf.A     = a;
        intf.B     = b;
        intf.C     = c;
        intf.cntl  = sel;
    endtask

    logic [W-1:0] ref_out;
    logic         ref_err;
    logic         r_rst;
    logic [W-1:0] r_a, r_b, r_c;
    logic [1:0]   r_sel;

    initial begin
        vecs[0]  = '{1'b1, 32'hDEADBEEF, 32'h0,        32'h0,        2'b00, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 2'b00, 32'h11111111, 1'b0};
        vecs[2]  = '{1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 2'b01, 32'h22222222, 1'b0};
        vecs[3]  = '{1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 2'b10, 32'h33333333, 1'b0};
        vecs[4]  = '{1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 2'b01, 32'h22222222, 1'b0};
        vecs[5]  = '{1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 2'b11, 32'h22222222, 1'b1};
        vecs[6]  = '{1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 2'b11, 32'h22222222, 1'b1};
        vecs[7]  = '{1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 2'b00, 32'h11111111, 1'b0};
        vecs[8]  = '{1'b1, 32'h11111111, 32'h22222222, 32'h33333333, 2'b11, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 2'b10, 32'h33333333, 1'b0};
        vecs[10] = '{1'b1, 32'h11111111, 32'h22222222, 32'h33333333, 2'b01, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 2'b11, 32'h0,        1'b1};
        vecs[12] = '{1'b0, 32'h11111111, 32'hA5A5A5A5, 32'h33333333, 2'b01, 32'hA5A5A5A5, 1'b0};
        vecs[13] = '{1'b0, 32'h80000001, 32'hA5A5A5A5, 32'h7FFFFFFE, 2'b10, 32'h7FFFFFFE, 1'b0};

        drive(1'b1, '0, '0, '0, 2'b00);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge intf.clk);
            drive(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sel);
            @(posedge intf.clk);
            #1;
            check($sformatf("vec%0d_out", i), intf.out, vecs[i].exp_out);
            check($sformatf("vec%0d_err", i), {{(W-1){1'b0}}, intf.sel_err},
                  {{(W-1){1'b0}}, vecs[i].exp_err});
        end

        // Data changing between edges must not reach the output until the next edge.
        @(negedge intf.clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
        @(posedge intf.clk);
        #1;
        check("midcyc_before", intf.out, 32'h0);
        @(negedge intf.clk);
        intf.A = 32'hFFFFFFFF;
        #2;
        check("midcyc_hold", intf.out, 32'h0);
        intf.cntl = 2'b01;
        #1;
        check("midcyc_cntl_hold", intf.out, 32'h0);
        intf.cntl = 2'b00;
        @(posedge intf.clk);
        #1;
        check("midcyc_after", intf.out, 32'hFFFFFFFF);

        // Reset then immediate resumption on the first edge with reset low.
        @(negedge intf.clk);
        drive(1'b1, 32'h12345678, 32'h0, 32'h0, 2'b00);
        @(posedge intf.clk);
        #1;
        check("rst_again", intf.out, 32'h0);
        @(negedge intf.clk);
        intf.reset = 1'b0;
        @(posedge intf.clk);
        #1;
        check("resume", intf.out, 32'h12345678);

        ref_out = 32'h12345678;
        ref_err = 1'b0;
        for (int n = 0; n < 1200; n++) begin
            @(negedge intf.clk);
            r_rst = ($urandom_range(0, 63) == 0);
            r_a   = $urandom;
            r_b   = $urandom;
            r_c   = $urandom;
            r_sel = 2'($urandom_range(0, 3));
            drive(r_rst, r_a, r_b, r_c, r_sel);
            @(posedge intf.clk);
            #1;
            if (r_rst) begin
                ref_out = '0;
                ref_err = 1'b0;
            end else begin
                unique case (r_sel)
                    2'b00: begin ref_out = r_a; ref_err = 1'b0; end
                    2'b01: begin ref_out = r_b; ref_err = 1'b0; end
                    2'b10: begin ref_out = r_c; ref_err = 1'b0; end
                    default: ref_err = 1'b1;
                endcase
            end
            check($sformatf("rand%0d_out", n), intf.out, ref_out);
            check($sformatf("rand%0d_err", n), {{(W-1){1'b0}}, intf.sel_err},
                  {{(W-1){1'b0}}, ref_err});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux.md
MUX -- requirements
Module: mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of A, B, C and MUXOut.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have port A, input, WIDTH, data source selected when cntl = 2'b00.
REQ-005 The block SHALL have port B, input, WIDTH, data source selected when cntl = 2'b01.
REQ-006 The block SHALL have port C, input, WIDTH, data source selected when cntl = 2'b10.
REQ-007 The block SHALL have port cntl, input, 2, select code.
REQ-008 The block SHALL have port MUXOut, output, WIDTH, registered selected data.
REQ-009 The block SHALL have port sel_err, output, 1, registered flag for an illegal select code.

Function
REQ-010 On each rising clk edge with reset low, MUXOut SHALL load A, B or C for cntl = 00, 01 or 10 respectively.
REQ-011 Latency SHALL be exactly one cycle: inputs sampled at edge N appear on MUXOut after edge N.
REQ-012 For cntl = 2'b11, MUXOut SHALL hold its previous value and sel_err SHALL be 1 after that edge.
REQ-013 sel_err SHALL be 0 after any edge where cntl is legal; it SHALL NOT be sticky.
REQ-014 Data SHALL pass bit-exact with no sign extension, truncation or arithmetic.
REQ-015 Changing cntl or data between edges SHALL NOT affect MUXOut until the next rising edge, so the output is glitch-free.
REQ-016 An X or Z on cntl SHALL be treated as illegal in simulation (hold value, sel_err = 1); synthesis need not model this.
REQ-017 No handshake SHALL exist; the block accepts a new selection every cycle.

Reset
REQ-018 When reset is high at a rising edge, MUXOut SHALL become 0 and sel_err SHALL become 0.
REQ-019 Reset SHALL take priority over any cntl value, including 2'b11, in the same cycle.
REQ-020 Reset asserted mid-stream SHALL discard the selection sampled at that edge.
REQ-021 Normal selection SHALL resume at the first edge with reset low.
REQ-022 Outputs SHALL be unknown-free from the first edge with reset high.

Structure
REQ-023 A shared package mux_pkg SHALL hold the typedef for the 2-bit select code (SEL_A = 00, SEL_B = 01, SEL_C = 10, SEL_ILLEGAL = 11) and the default width constant.
REQ-024 A combinational sub-module mux_sel_comb SHALL compute the next data value and illegal flag.
REQ-025 The top-level mux SHALL hold only the output registers and the reset logic.
REQ-026 The interface used to verify the block (MUX_intf) SHALL carry clk, reset, A, B, C, cntl, an output signal named out connected to MUXOut, and sel_err.

Verification
REQ-027 Reset: hold reset high for 1 edge with A = 32'hDEADBEEF and cntl = 00 -> MUXOut = 0 and sel_err = 0.
REQ-028 Legal selects: A = 32'h11111111, B = 32'h22222222, C = 32'h33333333; cntl sequence 00, 01, 10 on consecutive edges -> MUXOut = 11111111, 22222222, 33333333, each one cycle after sampling.
REQ-029 Illegal select: with MUXOut = 32'h22222222, apply cntl = 11 for 2 edges -> MUXOut stays 22222222 and sel_err = 1, then cntl = 00 -> sel_err = 0 and MUXOut = 11111111.
REQ-030 Reset priority: cntl = 11 together with reset high -> MUXOut = 0 and sel_err = 0.
REQ-031 Mid-cycle change: change A from 32'h0 to 32'hFFFFFFFF between edges with cntl = 00 -> MUXOut changes only at the next edge.
REQ-032 Randomized: at least 1000 cycles of random A, B, C and cntl compared against a one-cycle-delayed reference model -> zero mismatches.
